// File: rtl/prog_throttle.sv
// Two-button programmable rate generator: synchronised, debounced, auto-repeating
// level select driving a 50%-duty divided clock and a rising-edge tick enable.
module prog_throttle #(
  parameter int NUM_LEVELS    = 6,
  parameter int BASE_HALF     = 25000000,
  parameter int DB_LEN        = 65536,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 12500000,
  localparam int LEVEL_W = ($clog2(NUM_LEVELS) < 1) ? 1 : $clog2(NUM_LEVELS)
) (
  input  logic               CLK_50,
  input  logic               reset,
  input  logic               pb_freq_up,
  input  logic               pb_freq_dn,
  output logic               slow_clk,
  output logic               tick,
  output logic [LEVEL_W-1:0] freq_num,
  output logic               at_min,
  output logic               at_max,
  output logic               level_chg
);
  localparam int CNT_W    = ($clog2(BASE_HALF) < 1) ? 1 : $clog2(BASE_HALF);
  localparam int DB_W     = ($clog2(DB_LEN) < 1) ? 1 : $clog2(DB_LEN);
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  // Half-period minus one per level; unused padding entries alias level 0.
  logic [CNT_W-1:0] half_m1 [2**LEVEL_W];
  for (genvar g = 0; g < 2**LEVEL_W; g++) begin : g_half
    localparam int HIDX = (g < NUM_LEVELS) ? g : 0;
    assign half_m1[g] = CNT_W'(BASE_HALF / (HIDX + 1) - 1);
  end

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0]        sync1, sync2, db_state, db_prev;
  logic [1:0]        press, rep_evt, rep_mode, active;
  logic [DB_W-1:0]   db_cnt   [2];
  logic [HOLD_W-1:0] hold_cnt [2];
  logic              up_evt, dn_evt;
  logic [CNT_W-1:0]  count;

  assign press  = db_state & ~db_prev;
  assign active = db_state & ~{db_state[0], db_state[1]};

  always_comb begin
    rep_evt = '0;
    for (int i = 0; i < 2; i++) begin
      if (rep_mode[i]) rep_evt[i] = active[i] & (hold_cnt[i] == HOLD_W'(REPEAT_PERIOD));
      else             rep_evt[i] = active[i] & (hold_cnt[i] == HOLD_W'(REPEAT_DELAY));
    end
  end

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      db_state <= '0;
      db_prev  <= '0;
      rep_mode <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      sync1   <= {pb_freq_dn, pb_freq_up};
      sync2   <= sync1;
      db_prev <= db_state;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_state[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DB_LEN - 1)) begin
          db_cnt[i]   <= '0;
          db_state[i] <= ~db_state[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
        // After the first repeat the timer reloads to 1 and waits for REPEAT_PERIOD.
        if (!active[i]) begin
          hold_cnt[i] <= '0;
          rep_mode[i] <= 1'b0;
        end else if (rep_evt[i]) begin
          hold_cnt[i] <= HOLD_W'(1);
          rep_mode[i] <= 1'b1;
        end else begin
          hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
        end
      end
    end
  end

  assign up_evt = press[0] | rep_evt[0];
  assign dn_evt = press[1] | rep_evt[1];
  assign at_min = (freq_num == '0);
  assign at_max = (freq_num == LEVEL_W'(NUM_LEVELS - 1));

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      freq_num  <= '0;
      level_chg <= 1'b0;
    end else begin
      level_chg <= 1'b0;
      if (up_evt && !dn_evt && !at_max) begin
        freq_num  <= freq_num + LEVEL_W'(1);
        level_chg <= 1'b1;
      end else if (dn_evt && !up_evt && !at_min) begin
        freq_num  <= freq_num - LEVEL_W'(1);
        level_chg <= 1'b1;
      end
    end
  end

  // '>=' lets a shorter half-period take effect on the next edge without
  // clearing the count on a level change.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      count    <= '0;
      slow_clk <= 1'b0;
      tick     <= 1'b0;
    end else if (count >= half_m1[freq_num]) begin
      count    <= '0;
      slow_clk <= ~slow_clk;
      tick     <= ~slow_clk;
    end else begin
      count <= count + CNT_W'(1);
      tick  <= 1'b0;
    end
  end
endmodule

// File: doc/prog_throttle.md
Name: prog_throttle

Overview:
- Parametrised successor to the push-button frequency throttle.
- Two push-buttons step a level register between 0 and NUM_LEVELS-1. Each level selects a half-period from a constant table, and the block generates a 50%-duty slow_clk plus a one-cycle tick enable on each slow_clk rising edge.
- Adds over the previous generation: parametrised level count and debounce length, input synchronisers, one step per press with hold-to-auto-repeat, saturation flags, and glitch-free retiming when the level changes mid-period.
- Sits between the board buttons and the downstream paced logic, which must use tick as a clock enable on CLK_50.

Parameters:
- NUM_LEVELS, 6, number of frequency levels (>=2).
- BASE_HALF, 25000000, half-period in CLK_50 cycles at level 0 (1 Hz at 50 MHz).
- DB_LEN, 65536, consecutive stable samples required to accept a button state change.
- REPEAT_DELAY, 25000000, hold cycles before auto-repeat starts.
- REPEAT_PERIOD, 12500000, cycles between auto-repeat steps.
- Derived, not overridable: LEVEL_W = clog2(NUM_LEVELS), min 1; CNT_W = clog2(BASE_HALF).

Ports:
- CLK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- pb_freq_up  in  1  raw button, active-high, asynchronous to CLK_50.
- pb_freq_dn  in  1  raw button, active-high, asynchronous to CLK_50.
- slow_clk  out  1  registered 50%-duty divided clock.
- tick  out  1  one-cycle pulse, asserted in the cycle slow_clk goes 0->1.
- freq_num  out  LEVEL_W  current level.
- at_min  out  1  high when freq_num == 0.
- at_max  out  1  high when freq_num == NUM_LEVELS-1.
- level_chg  out  1  one-cycle pulse, asserted in the cycle freq_num takes a new value.

Behaviour:
- Reset values, applied asynchronously: freq_num=0, slow_clk=0, tick=0, level_chg=0, at_min=1, at_max=0, divider count=0, debounced states=0, repeat timers=0.
- Half-period table: HALF[k] = BASE_HALF/(k+1), integer division, computed at elaboration; HALF[k] >= 1 is required.
- Synchroniser: each button passes through 2 flops.
- Debounce: per-button counter.
  - The counter increments while the synced input differs from the debounced state and clears when they match.
  - When the counter reaches DB_LEN-1, the debounced state flips and the counter clears.
- Press event: rising edge of the debounced state, detected with a 1-flop delay.
- Auto-repeat, per button, active only while that debounced button is 1 and the other is 0:
  - A hold counter runs from the press event.
  - At REPEAT_DELAY a repeat event fires, then another every REPEAT_PERIOD cycles.
  - Release clears the counter.
- Step rules, evaluated each cycle:
  - up_evt & !dn_evt & !at_max -> freq_num+1.
  - dn_evt & !up_evt & !at_min -> freq_num-1.
  - Simultaneous up and down events -> no change.
  - Saturated request -> no change and no level_chg pulse; no wrap-around.
- Latency: with the pin held stable, freq_num updates on the (DB_LEN+3)th CLK_50 rising edge after the pin change. level_chg is asserted in that same cycle.
- at_min and at_max are combinational decodes of freq_num.
- Divider:
  - The count increments every cycle.
  - When count >= HALF[freq_num]-1: count goes to 0 and slow_clk toggles; tick=1 in that cycle iff slow_clk goes 0->1.
  - Using >= means a level increase that shortens the half-period below the current count toggles on the next edge. slow_clk never produces a high or low phase longer than the old HALF or shorter than 1 cycle.
  - The count is not cleared on a level change.
- Reset mid-operation: all state returns to reset values immediately; the first toggle after release occurs HALF[0] cycles later.
- Bounce shorter than DB_LEN cycles produces no event. Holding both buttons produces no steps and no repeat.

Test Plan:
Run with DB_LEN=4, BASE_HALF=60, NUM_LEVELS=4, REPEAT_DELAY=100, REPEAT_PERIOD=20.
- Reset, then 400 idle cycles -> freq_num=0, at_min=1; slow_clk toggles every 60 cycles; tick pulses every 120 cycles, each 1 cycle wide.
- Single clean up press of 10 cycles -> freq_num=1 exactly 7 edges after press; one level_chg pulse; half-period becomes 30.
- Up pin toggling every 2 cycles for 20 cycles, then low -> no freq_num change, no level_chg.
- Up held for 200 cycles from level 0 -> steps at press, then at +100 and +120, reaching 3; at_max=1; further repeats cause no change and no level_chg.
- Both pins pressed in the same cycle -> no change; then down alone from level 2 -> freq_num=1.
- Level 0 with count at 45, up event -> toggle on the next edge (45 >= 29), then every 30 cycles. Separately, reset asserted mid-period -> all outputs at reset values in the same cycle.
